// File: rtl/dma64_mem_responder_if.sv
// ---------------------------------------------------------------------------
// dma64_mem_responder_if
// Groups the 64-bit ESP-style DMA handshake between an accelerator (master)
// and a memory-side responder (slave).
//   read ctrl  : valid/ready plus index, length, size and user fields
//   read chnl  : valid/ready plus 64-bit beat, driven by the responder
//   write ctrl : valid/ready plus index, length, size and user fields
//   write chnl : valid/ready plus 64-bit beat, driven by the accelerator
// ---------------------------------------------------------------------------
interface dma64_mem_responder_if;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic [5:0]  dma_read_ctrl_data_user;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;

  logic        dma_write_ctrl_valid;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index;
  logic [31:0] dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic [5:0]  dma_write_ctrl_data_user;
  logic        dma_write_chnl_valid;
  logic        dma_write_chnl_ready;
  logic [63:0] dma_write_chnl_data;

  // Accelerator side: issues requests, consumes read beats, produces write beats.
  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_ctrl_data_user, dma_write_chnl_valid,
           dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  // Memory side: accepts requests, produces read beats, absorbs write beats.
  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_ctrl_data_user, dma_write_chnl_valid,
           dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface

// File: rtl/dma64_mem_responder.sv
// ---------------------------------------------------------------------------
// dma64_mem_responder
// Memory-side DMA target: serves read requests from an internal 64-bit word
// memory and absorbs write beats into it. Independent read and write engines,
// one outstanding transaction each. A host port loads and peeks the memory.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   dma               DMA handshake bundle (slave modport)
//   host_we/addr/wdata host write (dropped when a DMA write beat lands that cycle)
//   host_rdata        mem[host_addr], registered, one-cycle latency
//   rd_busy, wr_busy  a read / write transaction is in progress
//   err_size          sticky: a request with size != 64-bit was accepted
// ---------------------------------------------------------------------------
module dma64_mem_responder #(
  parameter int MEM_DEPTH       = 65536,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_ACK_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  dma64_mem_responder_if.slave         dma,
  input  logic                         host_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] host_addr,
  input  logic [63:0]                  host_wdata,
  output logic [63:0]                  host_rdata,
  output logic                         rd_busy,
  output logic                         wr_busy,
  output logic                         err_size
);

  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int ACK_W = (WRITE_ACK_DELAY < 1) ? 1 : $clog2(WRITE_ACK_DELAY + 1);
  localparam logic [2:0] SIZE_64 = 3'b011;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_STREAM} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_ACK}    wr_state_t;

  logic [63:0] mem [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Read engine
  // -------------------------------------------------------------------------
  rd_state_t        rd_state, rd_state_nxt;
  logic [AW-1:0]    rd_addr;
  logic [31:0]      rd_left;
  logic [LAT_W-1:0] rd_lat_cnt;
  logic [63:0]      rd_data_q;
  logic             rd_accept, rd_fire, rd_last, rd_lat_done, rd_load;

  assign dma.dma_read_ctrl_ready = (rd_state == R_IDLE);
  assign dma.dma_read_chnl_valid = (rd_state == R_STREAM);
  assign dma.dma_read_chnl_data  = rd_data_q;
  assign rd_busy                 = (rd_state != R_IDLE);

  assign rd_accept   = dma.dma_read_ctrl_valid && (rd_state == R_IDLE);
  assign rd_fire     = (rd_state == R_STREAM) && dma.dma_read_chnl_ready;
  assign rd_last     = (rd_left == 32'd1);
  // Counter starts at 1 on the accept edge, so reaching READ_LATENCY lands
  // the first beat exactly READ_LATENCY edges after acceptance.
  assign rd_lat_done = (rd_lat_cnt == LAT_W'(READ_LATENCY));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_state <= R_IDLE;
    else      rd_state <= rd_state_nxt;
  end

  // NOTE: every variable gets a default first, so no path through the case
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_load      = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        if (rd_accept) rd_state_nxt = R_WAIT;
      end
      R_WAIT: begin
        // A zero-length request spends one cycle here and returns, giving a
        // single-cycle busy pulse with no beats.
        if (rd_left == '0) begin
          rd_state_nxt = R_IDLE;
        end else if (rd_lat_done) begin
          rd_state_nxt = R_STREAM;
          rd_load      = 1'b1;
        end
      end
      R_STREAM: begin
        if (rd_fire) begin
          if (rd_last) rd_state_nxt = R_IDLE;
          else         rd_load      = 1'b1;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr    <= '0;
      rd_left    <= '0;
      rd_lat_cnt <= '0;
      rd_data_q  <= '0;
    end else begin
      if (rd_accept) begin
        rd_addr    <= dma.dma_read_ctrl_data_index[AW-1:0];
        rd_left    <= dma.dma_read_ctrl_data_length;
        rd_lat_cnt <= LAT_W'(1);
      end else if ((rd_state == R_WAIT) && !rd_lat_done) begin
        rd_lat_cnt <= rd_lat_cnt + 1'b1;
      end
      // Beat data is captured once when the beat first becomes valid and then
      // held until it is accepted; the address wraps naturally at AW bits.
      if (rd_load) begin
        rd_data_q <= mem[rd_addr];
        rd_addr   <= rd_addr + 1'b1;
      end
      if (rd_fire) rd_left <= rd_left - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Write engine
  // -------------------------------------------------------------------------
  wr_state_t        wr_state, wr_state_nxt;
  logic [AW-1:0]    wr_addr;
  logic [31:0]      wr_left;
  logic [ACK_W-1:0] wr_ack_cnt;
  logic             wr_accept, wr_beat_ok, wr_fire, wr_last, wr_ack_done;

  assign wr_accept   = dma.dma_write_ctrl_valid && (wr_state == W_IDLE);
  assign wr_beat_ok  = (wr_state == W_DATA) && (wr_left != '0);
  assign wr_fire     = wr_beat_ok && dma.dma_write_chnl_valid;
  assign wr_last     = (wr_left == 32'd1);
  assign wr_ack_done = (wr_ack_cnt == ACK_W'(WRITE_ACK_DELAY));

  assign dma.dma_write_ctrl_ready = (wr_state == W_IDLE);
  assign dma.dma_write_chnl_ready = wr_beat_ok;
  assign wr_busy                  = (wr_state != W_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_state <= W_IDLE;
    else      wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_IDLE: begin
        if (wr_accept) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        // Zero-length writes pass through here for one cycle with chnl_ready
        // held low: nothing was written, so there is nothing to acknowledge.
        if (wr_left == '0) begin
          wr_state_nxt = W_IDLE;
        end else if (wr_fire && wr_last) begin
          wr_state_nxt = (WRITE_ACK_DELAY == 0) ? W_IDLE : W_ACK;
        end
      end
      W_ACK: begin
        if (wr_ack_done) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr    <= '0;
      wr_left    <= '0;
      wr_ack_cnt <= '0;
    end else begin
      if (wr_accept) begin
        wr_addr <= dma.dma_write_ctrl_data_index[AW-1:0];
        wr_left <= dma.dma_write_ctrl_data_length;
      end
      if (wr_fire) begin
        wr_addr <= wr_addr + 1'b1;
        wr_left <= wr_left - 1'b1;
      end
      // Counts the idle cycles spent in W_ACK, starting at 1 on the edge
      // that took the last beat.
      if (wr_fire && wr_last)                    wr_ack_cnt <= ACK_W'(1);
      else if ((wr_state == W_ACK) && !wr_ack_done) wr_ack_cnt <= wr_ack_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Memory: single write port, DMA beats win; host reads never blocked
  // -------------------------------------------------------------------------
  // NOTE: the memory array is deliberately left out of reset; only the
  // control and output registers around it are reset.
  always_ff @(posedge clk) begin
    if (wr_fire)      mem[wr_addr]   <= dma.dma_write_chnl_data;
    else if (host_we) mem[host_addr] <= host_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) host_rdata <= '0;
    else      host_rdata <= mem[host_addr];
  end

  // Sticky size error; the transaction itself still runs as 64-bit beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_size <= 1'b0;
    end else if ((rd_accept && (dma.dma_read_ctrl_data_size  != SIZE_64)) ||
                 (wr_accept && (dma.dma_write_ctrl_data_size != SIZE_64))) begin
      err_size <= 1'b1;
    end
  end

  // User fields and index bits above the memory range carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{dma.dma_read_ctrl_data_user, dma.dma_write_ctrl_data_user,
                         dma.dma_read_ctrl_data_index[31:AW],
                         dma.dma_write_ctrl_data_index[31:AW]};

endmodule

// File: tb/tb_dma64_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_dma64_mem_responder
// Self-checking bench: a table of read requests plus hand-written sequences
// for wrap-around writes, zero-length requests, concurrent traffic with a
// host collision, sticky size error and reset mid-stream. Read beats are
// compared against a scoreboard queue filled from a bench-side memory model.
// ---------------------------------------------------------------------------
module tb_dma64_mem_responder;
  localparam int MEM_DEPTH       = 65536;
  localparam int READ_LATENCY    = 4;
  localparam int WRITE_ACK_DELAY = 2;
  localparam int AW              = $clog2(MEM_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [63:0]   host_wdata;
  logic [63:0]   host_rdata;
  logic          rd_busy, wr_busy, err_size;

  dma64_mem_responder_if dif ();

  dma64_mem_responder #(
    .MEM_DEPTH       (MEM_DEPTH),
    .READ_LATENCY    (READ_LATENCY),
    .WRITE_ACK_DELAY (WRITE_ACK_DELAY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dma        (dif),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .rd_busy    (rd_busy),
    .wr_busy    (wr_busy),
    .err_size   (err_size)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] model [int];
  logic [63:0] rd_q [$];
  bit          rd_toggle = 1'b0;
  bit          held      = 1'b0;
  logic [63:0] held_data;

  typedef struct {
    int         idx;
    int         len;
    logic [2:0] size;
    bit         tog;
    bit         exp_err;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-channel ready: constant high, or toggling every cycle.
  initial begin
    dif.dma_read_chnl_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rd_toggle) dif.dma_read_chnl_ready = ~dif.dma_read_chnl_ready;
      else           dif.dma_read_chnl_ready = 1'b1;
    end
  end

  // Read monitor: compares accepted beats with the scoreboard and checks
  // that a stalled beat does not change.
  always @(negedge clk) begin
    if (rst && dif.dma_read_chnl_valid) begin
      if (held) check("rd_hold_stable", dif.dma_read_chnl_data, held_data);
      if (dif.dma_read_chnl_ready) begin
        held = 1'b0;
        check("rd_beat_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) check("rd_beat_data", dif.dma_read_chnl_data, rd_q.pop_front());
      end else begin
        held      = 1'b1;
        held_data = dif.dma_read_chnl_data;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic host_write(input int a, input logic [63:0] d);
    host_we    = 1'b1;
    host_addr  = AW'(a);
    host_wdata = d;
    @(posedge clk); #1;
    host_we    = 1'b0;
    model[a]   = d;
  endtask

  task automatic host_check(input string name, input int a);
    host_addr = AW'(a);
    @(posedge clk); #1;
    check(name, host_rdata, model[a]);
  endtask

  task automatic rd_req(input int idx, input int len, input logic [2:0] size, input bit tog);
    int n;
    rd_toggle = tog;
    for (int k = 0; k < len; k++) rd_q.push_back(model[(idx + k) % MEM_DEPTH]);
    check("rd_ctrl_ready_idle", 64'(dif.dma_read_ctrl_ready), 64'd1);
    dif.dma_read_ctrl_valid       = 1'b1;
    dif.dma_read_ctrl_data_index  = 32'(idx);
    dif.dma_read_ctrl_data_length = 32'(len);
    dif.dma_read_ctrl_data_size   = size;
    dif.dma_read_ctrl_data_user   = 6'h2a;
    @(posedge clk); #1;
    dif.dma_read_ctrl_valid = 1'b0;
    check("rd_busy_after_accept", 64'(rd_busy), 64'd1);
    check("rd_ctrl_ready_after_accept", 64'(dif.dma_read_ctrl_ready), 64'd0);
    if (len == 0) begin
      check("rd_len0_no_valid", 64'(dif.dma_read_chnl_valid), 64'd0);
      @(posedge clk); #1;
      check("rd_len0_ready_back", 64'(dif.dma_read_ctrl_ready), 64'd1);
      check("rd_len0_busy_clear", 64'(rd_busy), 64'd0);
      check("rd_len0_no_valid2", 64'(dif.dma_read_chnl_valid), 64'd0);
    end else begin
      n = 0;
      while (!dif.dma_read_chnl_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("rd_first_beat_latency", 64'(n), 64'(READ_LATENCY));
      n = 0;
      while (rd_q.size() != 0 && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      check("rd_drain_in_time", 64'(n < 400), 64'd1);
      check("rd_done_valid_low", 64'(dif.dma_read_chnl_valid), 64'd0);
      check("rd_done_ctrl_ready", 64'(dif.dma_read_ctrl_ready), 64'd1);
      check("rd_done_busy_clear", 64'(rd_busy), 64'd0);
    end
    rd_toggle = 1'b0;
  endtask

  task automatic wr_req(input int idx, input int len, input logic [2:0] size,
                        input logic [63:0] base, input bit collide);
    int n;
    check("wr_ctrl_ready_idle", 64'(dif.dma_write_ctrl_ready), 64'd1);
    dif.dma_write_ctrl_valid       = 1'b1;
    dif.dma_write_ctrl_data_index  = 32'(idx);
    dif.dma_write_ctrl_data_length = 32'(len);
    dif.dma_write_ctrl_data_size   = size;
    dif.dma_write_ctrl_data_user   = 6'h15;
    @(posedge clk); #1;
    dif.dma_write_ctrl_valid = 1'b0;
    check("wr_busy_after_accept", 64'(wr_busy), 64'd1);
    check("wr_ctrl_ready_after_accept", 64'(dif.dma_write_ctrl_ready), 64'd0);
    if (len == 0) begin
      check("wr_len0_no_chnl_ready", 64'(dif.dma_write_chnl_ready), 64'd0);
      @(posedge clk); #1;
      check("wr_len0_ready_back", 64'(dif.dma_write_ctrl_ready), 64'd1);
      check("wr_len0_busy_clear", 64'(wr_busy), 64'd0);
    end else begin
      for (int k = 0; k < len; k++) begin
        dif.dma_write_chnl_valid = 1'b1;
        dif.dma_write_chnl_data  = base + 64'(k);
        if (collide && k == 0) begin
          host_we    = 1'b1;
          host_addr  = AW'(idx);
          host_wdata = 64'hdead_beef_0000_0001;
        end
        check("wr_chnl_ready_in_data", 64'(dif.dma_write_chnl_ready), 64'd1);
        @(posedge clk); #1;
        host_we = 1'b0;
        model[(idx + k) % MEM_DEPTH] = base + 64'(k);
      end
      dif.dma_write_chnl_valid = 1'b0;
      check("wr_chnl_ready_drop", 64'(dif.dma_write_chnl_ready), 64'd0);
      n = 0;
      while (!dif.dma_write_ctrl_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("wr_ack_delay", 64'(n), 64'(WRITE_ACK_DELAY));
      check("wr_done_busy_clear", 64'(wr_busy), 64'd0);
    end
  endtask

  initial begin
    int n;
    rst                            = 1'b0;
    host_we                        = 1'b0;
    host_addr                      = '0;
    host_wdata                     = '0;
    dif.dma_read_ctrl_valid        = 1'b0;
    dif.dma_read_ctrl_data_index   = '0;
    dif.dma_read_ctrl_data_length  = '0;
    dif.dma_read_ctrl_data_size    = 3'b011;
    dif.dma_read_ctrl_data_user    = '0;
    dif.dma_write_ctrl_valid       = 1'b0;
    dif.dma_write_ctrl_data_index  = '0;
    dif.dma_write_ctrl_data_length = '0;
    dif.dma_write_ctrl_data_size   = 3'b011;
    dif.dma_write_ctrl_data_user   = '0;
    dif.dma_write_chnl_valid       = 1'b0;
    dif.dma_write_chnl_data        = '0;

    vecs[0] = '{4,             8, 3'b011, 1'b0, 1'b0};
    vecs[1] = '{4,             8, 3'b011, 1'b1, 1'b0};
    vecs[2] = '{0,             0, 3'b011, 1'b0, 1'b0};
    vecs[3] = '{MEM_DEPTH - 2, 4, 3'b011, 1'b1, 1'b0};
    vecs[4] = '{7,             1, 3'b011, 1'b0, 1'b0};
    vecs[5] = '{10,            5, 3'b010, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_ctrl_ready",  64'(dif.dma_read_ctrl_ready),  64'd1);
    check("rst_wr_ctrl_ready",  64'(dif.dma_write_ctrl_ready), 64'd1);
    check("rst_rd_chnl_valid",  64'(dif.dma_read_chnl_valid),  64'd0);
    check("rst_wr_chnl_ready",  64'(dif.dma_write_chnl_ready), 64'd0);
    check("rst_rd_chnl_data",   dif.dma_read_chnl_data,        64'd0);
    check("rst_host_rdata",     host_rdata,                    64'd0);
    check("rst_busy",           64'({rd_busy, wr_busy}),       64'd0);
    check("rst_err_size",       64'(err_size),                 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Memory preload through the host port
    for (int i = 0; i < 16; i++)                 host_write(i, 64'(i * 3));
    for (int i = MEM_DEPTH - 4; i < MEM_DEPTH; i++) host_write(i, 64'h5000 + 64'(i));
    for (int i = 100; i < 116; i++)              host_write(i, 64'hc000_0000 + 64'(i));
    host_check("host_peek_5", 5);

    // Table-driven read requests
    for (int i = 0; i < 6; i++) begin
      rd_req(vecs[i].idx, vecs[i].len, vecs[i].size, vecs[i].tog);
      check("err_size_after_row", 64'(err_size), 64'(vecs[i].exp_err));
    end

    // Wrapping write, then peek via host and read it back over DMA
    wr_req(MEM_DEPTH - 2, 4, 3'b011, 64'ha0, 1'b0);
    host_check("wrap_mem_depth_m2", MEM_DEPTH - 2);
    host_check("wrap_mem_depth_m1", MEM_DEPTH - 1);
    host_check("wrap_mem_0",        0);
    host_check("wrap_mem_1",        1);
    rd_req(MEM_DEPTH - 2, 4, 3'b011, 1'b0);

    // Zero-length read and write together
    fork
      rd_req(5, 0, 3'b011, 1'b0);
      wr_req(5, 0, 3'b011, 64'h0, 1'b0);
    join

    // Concurrent read and write, host write colliding with the first beat
    fork
      rd_req(100, 16, 3'b011, 1'b0);
      wr_req(200, 16, 3'b011, 64'hbeef_0000, 1'b1);
    join
    host_check("collide_mem_200", 200);
    host_check("mem_215",         215);
    check("err_size_sticky", 64'(err_size), 64'd1);

    // Reset in the middle of a read stream
    for (int k = 0; k < 8; k++) rd_q.push_back(model[k]);
    dif.dma_read_ctrl_valid       = 1'b1;
    dif.dma_read_ctrl_data_index  = 32'd0;
    dif.dma_read_ctrl_data_length = 32'd8;
    dif.dma_read_ctrl_data_size   = 3'b011;
    @(posedge clk); #1;
    dif.dma_read_ctrl_valid = 1'b0;
    n = 0;
    while (!dif.dma_read_chnl_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_stream_started", 64'(dif.dma_read_chnl_valid), 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid_drop",  64'(dif.dma_read_chnl_valid),  64'd0);
    check("rst_mid_rd_ready",    64'(dif.dma_read_ctrl_ready),  64'd1);
    check("rst_mid_wr_ready",    64'(dif.dma_write_ctrl_ready), 64'd1);
    check("rst_mid_err_clear",   64'(err_size),                 64'd0);
    check("rst_mid_busy_clear",  64'({rd_busy, wr_busy}),       64'd0);
    rd_q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_no_beat", 64'(dif.dma_read_chnl_valid), 64'd0);
    end
    check("post_rst_rd_ready", 64'(dif.dma_read_ctrl_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
